// File: rtl/dcache_port_arb_pkg.sv
// +----------------------------------------------------------------------+
// | sys_defs : shared store-queue packet type and arbiter defaults       |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package sys_defs;

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  usebytes;
      logic [31:0] data;
   } SQ_ENTRY_PACKET;

   localparam int WB_DEPTH_DEFAULT     = 4;
   localparam int STARVE_LIMIT_DEFAULT = 4;

endpackage

`default_nettype wire

// File: rtl/dcache_port_arb_fifo.sv
// +----------------------------------------------------------------------+
// | store_wb_fifo : 3-in / 1-out circular write buffer with hazard view  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module store_wb_fifo
   import sys_defs::*;
#(
   parameter int   DEPTH = WB_DEPTH_DEFAULT,
   localparam int  PW    = $clog2(DEPTH),
   localparam int  CW    = PW + 1
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [2:0]                  enq_valid,
   input  SQ_ENTRY_PACKET [2:0]        enq_entry,
   input  logic                        deq,
   output logic [CW-1:0]               count,
   output SQ_ENTRY_PACKET              head_entry,
   output logic [DEPTH-1:0]            entry_valid,
   output logic [DEPTH-1:0][29:0]      entry_word
);

   SQ_ENTRY_PACKET        mem_q [DEPTH];
   logic [PW-1:0]         head_q, head_d;
   logic [PW-1:0]         tail_q, tail_d;
   logic [CW-1:0]         count_q, count_d;
   logic [CW-1:0]         n_enq;
   logic [2:0][PW-1:0]    slot;

   // Accepted lanes pack densely at the tail in lane order, skipping gaps.
   always_comb begin
      n_enq   = CW'(enq_valid[0]) + CW'(enq_valid[1]) + CW'(enq_valid[2]);
      slot[0] = tail_q;
      slot[1] = tail_q + PW'(enq_valid[0]);
      slot[2] = tail_q + PW'(enq_valid[0]) + PW'(enq_valid[1]);
      tail_d  = tail_q + n_enq[PW-1:0];
      head_d  = head_q + PW'(deq);
      count_d = count_q + n_enq - CW'(deq);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clock) begin
      for (int l = 0; l < 3; l++) begin
         if (enq_valid[l]) mem_q[slot[l]] <= enq_entry[l];
      end
   end

   generate
      for (genvar j = 0; j < DEPTH; j++) begin : g_entry
         logic [PW-1:0] offset;
         assign offset         = PW'(j) - head_q;
         assign entry_valid[j] = (CW'(offset) < count_q);
         assign entry_word[j]  = mem_q[j].addr[31:2];
      end
   endgenerate

   assign count      = count_q;
   assign head_entry = mem_q[head_q];

endmodule

`default_nettype wire

// File: rtl/dcache_port_arb.sv
// +----------------------------------------------------------------------+
// | dcache_port_arb : D-cache port arbiter, store drain vs two load pipes|
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module dcache_port_arb
   import sys_defs::*;
#(
   parameter int WB_DEPTH     = WB_DEPTH_DEFAULT,
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [2:0]           retire_valid,
   input  SQ_ENTRY_PACKET [2:0] retire_store,
   output logic [1:0]           wb_space,
   output logic                 wb_overflow,
   input  logic [1:0]           load_req,
   input  logic [1:0][31:0]     load_addr,
   output logic [1:0]           load_gnt,
   output logic                 dc_req,
   output logic                 dc_we,
   output logic [31:0]          dc_addr,
   output logic [31:0]          dc_wdata,
   output logic [3:0]           dc_be,
   input  logic                 dc_ready
);

   localparam int CW = $clog2(WB_DEPTH) + 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   logic [CW-1:0]               wb_count;
   logic [CW-1:0]               free;
   SQ_ENTRY_PACKET              head;
   logic [WB_DEPTH-1:0]         entry_valid;
   logic [WB_DEPTH-1:0][29:0]   entry_word;
   logic [2:0]                  enq_ok;
   logic [1:0]                  nvalid;
   logic [1:0]                  blocked, unblk;
   logic                        store_cand, load_cand, sel, deq, load_fire;
   logic                        rr_q, rr_d;
   logic [SW-1:0]               starve_q, starve_d;
   logic                        overflow_q, overflow_d;

   store_wb_fifo #(.DEPTH(WB_DEPTH)) u_wb (
      .clock       (clock),
      .reset       (reset),
      .enq_valid   (enq_ok),
      .enq_entry   (retire_store),
      .deq         (deq),
      .count       (wb_count),
      .head_entry  (head),
      .entry_valid (entry_valid),
      .entry_word  (entry_word)
   );

   // Space reflects registered occupancy only; youngest lanes beyond it drop.
   always_comb begin
      free     = CW'(WB_DEPTH) - wb_count;
      wb_space = (free >= CW'(3)) ? 2'd3 : free[1:0];
      nvalid   = 2'd0;
      enq_ok   = 3'b000;
      for (int l = 0; l < 3; l++) begin
         if (retire_valid[l]) begin
            nvalid    = nvalid + 2'd1;
            enq_ok[l] = (nvalid <= wb_space);
         end
      end
      overflow_d = overflow_q | (|(retire_valid & ~enq_ok));
   end

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         blocked[i] = 1'b0;
         for (int j = 0; j < WB_DEPTH; j++) begin
            if (entry_valid[j] && (entry_word[j] == load_addr[i][31:2])) blocked[i] = 1'b1;
         end
      end
      unblk = load_req & ~blocked;

      store_cand = (wb_count != '0) &&
                   ((unblk == 2'b00) || (wb_count == CW'(WB_DEPTH)) ||
                    (starve_q == SW'(STARVE_LIMIT)) || (|(load_req & blocked)));

      load_cand = 1'b0;
      sel       = 1'b0;
      if (!store_cand) begin
         case (unblk)
            2'b11:   begin load_cand = 1'b1; sel = rr_q; end
            2'b01:   begin load_cand = 1'b1; sel = 1'b0; end
            2'b10:   begin load_cand = 1'b1; sel = 1'b1; end
            default: begin load_cand = 1'b0; sel = 1'b0; end
         endcase
      end

      deq       = store_cand & dc_ready;
      load_fire = load_cand & dc_ready;

      rr_d = (load_fire && (load_req == 2'b11)) ? ~sel : rr_q;

      if ((wb_count != '0) && !deq)
         starve_d = (starve_q == SW'(STARVE_LIMIT)) ? starve_q : starve_q + SW'(1);
      else
         starve_d = '0;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rr_q       <= 1'b0;
         starve_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         rr_q       <= rr_d;
         starve_q   <= starve_d;
         overflow_q <= overflow_d;
      end
   end

   // Request and grants are forced low the instant reset asserts.
   assign dc_req      = reset & (store_cand | load_cand);
   assign load_gnt    = (reset & load_fire) ? (sel ? 2'b10 : 2'b01) : 2'b00;
   assign dc_we       = store_cand;
   assign dc_addr     = store_cand ? head.addr : load_addr[sel];
   assign dc_wdata    = store_cand ? head.data : 32'h0;
   assign dc_be       = store_cand ? head.usebytes : 4'h0;
   assign wb_overflow = overflow_q;

endmodule

`default_nettype wire
